// File: rtl/t_ff_bank_if.sv
// Control/data bundle for t_ff_bank: step controls, load path, state and wrap outputs.
interface t_ff_bank_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             mode;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             wrap;

  modport master (output en, mode, up, load, t, d, input q, wrap);
  modport slave  (input en, mode, up, load, t, d, output q, wrap);
endinterface

// File: rtl/t_ff_bank.sv
// Bank of WIDTH T flip-flops: per-bit toggle (mode 0) or up/down counter (mode 1), parallel load, wrap pulse.
// Define T_SAT_EN to make mode 1 saturate at the boundary instead of wrapping.
module t_ff_bank #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic         clk,
  input logic         rst,
  t_ff_bank_if.slave  bus
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] t_cnt;
  logic             carry;

  always_comb begin
    // Ripple the T-FF enable chain; after the last bit, carry flags all-ones (up) / all-zeros (down).
    t_cnt = '0;
    carry = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      t_cnt[i] = carry;
      carry    = carry & (bus.up ? q_q[i] : ~q_q[i]);
    end

    q_d    = q_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      q_d = bus.d;
    end else if (bus.en) begin
      if (!bus.mode) begin
        q_d = q_q ^ bus.t;
      end else begin
`ifdef T_SAT_EN
        if (carry) begin
          wrap_d = 1'b1;
        end else begin
          q_d = q_q ^ t_cnt;
        end
`else
        q_d    = q_q ^ t_cnt;
        wrap_d = carry;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RST_VAL;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.wrap = wrap_q;

endmodule
